// File: rtl/mux8_rr_sched_pkg.sv
// Shared types and helpers for the round-robin mux scheduler.
package mux8_rr_sched_pkg;

   localparam int unsigned NREQ  = 8;
   localparam int unsigned SEL_W = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   function automatic logic [NREQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
      logic [NREQ-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mux8_rr_sched_rr_pick8.sv
// Round-robin picker: first set request at or above start, wrapping 7 to 0.
module rr_pick8
   import mux8_rr_sched_pkg::*;
(
   input  logic [NREQ-1:0]  i_req,
   input  logic [SEL_W-1:0] i_start,
   output logic [SEL_W-1:0] o_idx,
   output logic             o_any
);

   logic [NREQ-1:0]  w_rot;
   logic [SEL_W-1:0] w_off;
   logic [SEL_W-1:0] w_src;

   // Rotate so that requester i_start lands at bit 0.
   always_comb begin
      w_rot = '0;
      w_src = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         w_src    = SEL_W'(i) + i_start;
         w_rot[i] = i_req[w_src];
      end
   end

   // Lowest set bit wins; scanning downward lets the lowest index overwrite last.
   always_comb begin
      w_off = '0;
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_off = SEL_W'(i);
         end
      end
   end

   assign o_idx = w_off + i_start;
   assign o_any = |i_req;

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler driving the select of a shared 8:1 mux, with a hold limit per grant.
module mux8_rr_sched
   import mux8_rr_sched_pkg::*;
#(
   parameter int unsigned MAXHOLD = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [NREQ-1:0]  i_req,
   output logic [SEL_W-1:0] o_s,
   output logic [NREQ-1:0]  o_gnt,
   output logic             o_valid
);

   localparam int unsigned CNT_W = $clog2(MAXHOLD + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAXHOLD);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [SEL_W-1:0] r_ptr;
   logic [SEL_W-1:0] w_ptr_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [SEL_W-1:0] r_s;
   logic [SEL_W-1:0] w_s_nxt;
   logic [NREQ-1:0]  r_gnt;
   logic [NREQ-1:0]  w_gnt_nxt;
   logic             r_valid;
   logic             w_valid_nxt;

   logic [SEL_W-1:0] w_s_inc;
   logic [SEL_W-1:0] w_start;
   logic [SEL_W-1:0] w_idx;
   logic             w_any;
   logic             w_hold;

   assign w_s_inc = r_s + SEL_W'(1);
   // While granting, the picker is only consulted at release, so scan past the grantee.
   assign w_start = (r_state == GRANT) ? w_s_inc : r_ptr;
   assign w_hold  = i_req[r_s] && (r_cnt < MAX_CNT);

   rr_pick8 u_pick (
      .i_req   (i_req),
      .i_start (w_start),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      w_s_nxt     = r_s;
      w_gnt_nxt   = r_gnt;
      w_valid_nxt = r_valid;
      unique case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_nxt = GRANT;
               w_cnt_nxt   = CNT_W'(1);
               w_s_nxt     = w_idx;
               w_gnt_nxt   = onehot8(w_idx);
               w_valid_nxt = 1'b1;
            end
         end
         GRANT: begin
            if (w_hold) begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end else begin
               w_ptr_nxt = w_s_inc;
               if (w_any) begin
                  w_cnt_nxt   = CNT_W'(1);
                  w_s_nxt     = w_idx;
                  w_gnt_nxt   = onehot8(w_idx);
                  w_valid_nxt = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = '0;
                  w_gnt_nxt   = '0;
                  w_valid_nxt = 1'b0;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_cnt   <= '0;
         r_s     <= '0;
         r_gnt   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_cnt   <= w_cnt_nxt;
         r_s     <= w_s_nxt;
         r_gnt   <= w_gnt_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   assign o_s     = r_s;
   assign o_gnt   = r_gnt;
   assign o_valid = r_valid;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Directed bench for mux8_rr_sched with MAXHOLD=4 and hand-computed grant sequences.
module tb_mux8_rr_sched;

   logic       r_clk;
   logic       r_rst;
   logic [7:0] r_req;
   logic [2:0] w_s;
   logic [7:0] w_gnt;
   logic       w_valid;

   int n_cmp;
   int n_bad;

   mux8_rr_sched #(
      .MAXHOLD (4)
   ) u_dut (
      .i_clk   (r_clk),
      .i_rst   (r_rst),
      .i_req   (r_req),
      .o_s     (w_s),
      .o_gnt   (w_gnt),
      .o_valid (w_valid)
   );

   initial r_clk = 1'b0;
   always #5 r_clk = ~r_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge r_clk);
      #1;
   endtask

   // Expect an active grant to requester idx.
   task automatic expect_gnt(input string tag, input int idx);
      logic [7:0] oh;
      oh = 8'h01 << idx;
      check({tag, ".s"}, 32'(w_s), 32'(idx));
      check({tag, ".gnt"}, 32'(w_gnt), 32'(oh));
      check({tag, ".valid"}, 32'(w_valid), 32'd1);
   endtask

   task automatic expect_idle(input string tag, input int s_exp);
      check({tag, ".s"}, 32'(w_s), 32'(s_exp));
      check({tag, ".gnt"}, 32'(w_gnt), 32'd0);
      check({tag, ".valid"}, 32'(w_valid), 32'd0);
   endtask

   task automatic do_reset();
      r_rst = 1'b1;
      tick();
      expect_idle("rst", 0);
      r_rst = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;

      // 1: reset with all requests high, then first grant to 0.
      r_rst = 1'b1;
      r_req = 8'hFF;
      tick();
      expect_idle("t1_rst0", 0);
      tick();
      expect_idle("t1_rst1", 0);
      r_rst = 1'b0;
      tick();
      expect_gnt("t1_first", 0);

      // 3: full rotation with constant requests, 4 cycles each, wrap 7->0.
      for (int c = 1; c < 4; c++) begin
         tick();
         expect_gnt($sformatf("t3_g0_c%0d", c), 0);
      end
      for (int k = 1; k <= 8; k++) begin
         for (int c = 0; c < 4; c++) begin
            tick();
            expect_gnt($sformatf("t3_g%0d_c%0d", k, c), k % 8);
         end
      end
      tick();
      expect_gnt("t3_after", 1);

      // 2: lone requester 5 stays granted through repeated hold-limit re-grants.
      r_req = 8'h00;
      do_reset();
      r_req = 8'h20;
      for (int c = 0; c < 10; c++) begin
         tick();
         expect_gnt($sformatf("t2_c%0d", c), 5);
      end
      r_req = 8'h00;
      tick();
      expect_idle("t2_drop", 5);

      // 4: early drop hands over to 6 without a bubble.
      r_req = 8'h44;
      do_reset();
      tick();
      expect_gnt("t4_g2a", 2);
      tick();
      expect_gnt("t4_g2b", 2);
      r_req = 8'h40;
      tick();
      expect_gnt("t4_g6", 6);

      // 5: release 6 to idle, pointer now 7, so 0 beats 6.
      r_req = 8'h00;
      tick();
      expect_idle("t5_idle", 6);
      r_req = 8'h41;
      tick();
      expect_gnt("t5_g0", 0);
      for (int c = 2; c <= 4; c++) begin
         tick();
         expect_gnt($sformatf("t5_hold%0d", c), 0);
      end
      tick();
      expect_gnt("t5_g6", 6);

      // 6: reset in the middle of a grant to 3.
      r_req = 8'h08;
      tick();
      expect_gnt("t6_g3", 3);
      tick();
      expect_gnt("t6_hold", 3);
      r_rst = 1'b1;
      tick();
      expect_idle("t6_rst", 0);
      r_rst = 1'b0;
      tick();
      expect_gnt("t6_regrant", 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
